ps2_key_ctrl: RTL

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

---
 rtl/ps2_key_ctrl_pkg.sv | 45 ++++
 rtl/ps2_key_ctrl_fifo.sv | 76 +++++++
 rtl/ps2_key_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ps2_key_ctrl_pkg.sv
// Shared constants for the PS/2 key controller: scan-code prefixes, discard set,
// decoder state encoding and key-event field positions.
// Pure declarations; no logic, no latency, no flow control.
package ps2_key_ctrl_pkg;

    // Scan-code prefixes that steer the decoder rather than produce events.
    localparam logic [7:0] SC_EXT  = 8'hE0;   // extended key prefix
    localparam logic [7:0] SC_BRK  = 8'hF0;   // break (release) prefix
    localparam logic [7:0] SC_SKIP = 8'hE1;   // Pause/Break sequence prefix

    // Bytes that are keyboard status/acknowledge traffic, never key codes.
    localparam logic [7:0] DC_ERR0 = 8'h00;   // buffer overrun / error
    localparam logic [7:0] DC_BAT  = 8'hAA;   // self-test passed
    localparam logic [7:0] DC_ECHO = 8'hEE;   // echo response
    localparam logic [7:0] DC_ACK  = 8'hFA;   // command acknowledge
    localparam logic [7:0] DC_BATF = 8'hFC;   // self-test failed
    localparam logic [7:0] DC_DIAG = 8'hFD;   // internal failure
    localparam logic [7:0] DC_RSND = 8'hFE;   // resend request
    localparam logic [7:0] DC_ERR1 = 8'hFF;   // buffer overrun / error

    // Decoder states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } dec_state_t;

    // Key-event word layout: {ext, brk, code[7:0]}.
    localparam int KEY_W        = 10;
    localparam int KEY_EXT_POS  = 9;
    localparam int KEY_BRK_POS  = 8;
    localparam int KEY_CODE_LSB = 0;
    localparam int KEY_CODE_W   = 8;

    function automatic logic is_discard(input logic [7:0] b);
        case (b)
            DC_ERR0, DC_BAT, DC_ECHO, DC_ACK,
            DC_BATF, DC_DIAG, DC_RSND, DC_ERR1: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_key_ctrl_fifo.sv
// key_fifo: show-ahead event FIFO, DEPTH entries (power of two) of WIDTH bits.
// Latency: a push is visible on head_dat/head_vld/count the cycle after the write edge.
// Backpressure: push while full is dropped (drop pulses) unless a pop happens on the same edge.
// Ports: clk/rst; push_vld/push_dat write side; pop_req advances head (ignored when empty);
//        head_dat (0 when empty), head_vld, full, drop (comb), count (0..DEPTH).
module key_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_req,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     head_vld,
    output logic                     full,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic empty;
    logic do_pop;
    logic do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop_req && !empty;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign do_push = push_vld && (!full || do_pop);
    assign drop    = push_vld && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer wrap is plain overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observable once count covers it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_vld = !empty;
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: turns a PS/2 byte stream into {ext, brk, code} key events held in a FIFO.
// Latency: event visible on keyData/keyValid one cycle after the edge that samples the strobe.
// Backpressure: none toward the receiver; events arriving while full are dropped and flagged sticky.
// Ports: clk, rst (async, active high); scanData/scanInt from the PS/2 receiver (rising scanInt =
//        new byte); rdEn pops head; clrOvf clears overflow; keyData/keyValid/fifoFull/overflow/
//        count status; irq = keyValid | overflow.
module ps2_key_ctrl
    import ps2_key_ctrl_pkg::*;
#(
    parameter int DEPTH    = 8,   // power of two, 2..64
    parameter int SKIP_LEN = 7    // bytes swallowed after E1, must be >= 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               scanData,
    input  logic                     scanInt,
    input  logic                     rdEn,
    input  logic                     clrOvf,
    output logic [KEY_W-1:0]         keyData,
    output logic                     keyValid,
    output logic                     fifoFull,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     irq
);

    localparam int SW = (SKIP_LEN < 2) ? 1 : $clog2(SKIP_LEN + 1);

    // Edge detect. The delay flop resets high so a level already high when
    // reset releases is not mistaken for a fresh byte.
    logic scan_int_dly_q, scan_int_dly_d;
    logic strobe;

    assign scan_int_dly_d = scanInt;
    assign strobe         = scanInt && !scan_int_dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) scan_int_dly_q <= 1'b1;
        else     scan_int_dly_q <= scan_int_dly_d;
    end

    // Decoder FSM: state register.
    dec_state_t     state_q, state_d;
    logic [SW-1:0]  skip_cnt_q, skip_cnt_d;
    logic           discard;

    assign discard = is_discard(scanData);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            skip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    // Decoder FSM: next state. Nothing moves without a strobe.
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        if (strobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (scanData == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (scanData == SC_BRK) begin
                        state_d = ST_BRK;
                    end else if (scanData == SC_SKIP) begin
                        state_d    = ST_SKIP;
                        skip_cnt_d = SW'(SKIP_LEN);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (discard)                 state_d = ST_IDLE;
                    else if (scanData == SC_BRK) state_d = ST_EXT_BRK;
                    else if (scanData == SC_EXT) state_d = ST_EXT;
                    else                         state_d = ST_IDLE;
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                end
                ST_SKIP: begin
                    // Every byte counts here, discard-set bytes included.
                    skip_cnt_d = skip_cnt_q - SW'(1);
                    if (skip_cnt_q <= SW'(1)) state_d = ST_IDLE;
                end
                default: begin
                    state_d    = ST_IDLE;
                    skip_cnt_d = '0;
                end
            endcase
        end
    end

    // Decoder FSM: outputs (event push), Mealy on the strobe.
    logic             push_vld;
    logic             push_ext;
    logic             push_brk;
    logic [KEY_W-1:0] push_dat;

    always_comb begin
        push_vld = 1'b0;
        push_ext = 1'b0;
        push_brk = 1'b0;
        if (strobe && !discard) begin
            case (state_q)
                ST_IDLE: begin
                    push_vld = (scanData != SC_EXT) && (scanData != SC_BRK) &&
                               (scanData != SC_SKIP);
                end
                ST_EXT: begin
                    push_vld = (scanData != SC_EXT) && (scanData != SC_BRK);
                    push_ext = 1'b1;
                end
                ST_BRK: begin
                    push_vld = 1'b1;
                    push_brk = 1'b1;
                end
                ST_EXT_BRK: begin
                    push_vld = 1'b1;
                    push_ext = 1'b1;
                    push_brk = 1'b1;
                end
                default: push_vld = 1'b0;
            endcase
        end
    end

    always_comb begin
        push_dat = '0;
        push_dat[KEY_CODE_LSB +: KEY_CODE_W] = scanData;
        push_dat[KEY_EXT_POS]                = push_ext;
        push_dat[KEY_BRK_POS]                = push_brk;
    end

    // Event FIFO.
    logic fifo_drop;

    key_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_req  (rdEn),
        .head_dat (keyData),
        .head_vld (keyValid),
        .full     (fifoFull),
        .drop     (fifo_drop),
        .count    (count)
    );

    // Sticky overflow. A drop on the same edge as clrOvf wins so no loss goes unreported.
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (fifo_drop)   overflow_d = 1'b1;
        else if (clrOvf) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
    assign irq      = keyValid || overflow_q;

endmodule
